execute_stage: RTL and testbench

//  EX stage of the 5-stage MIPS pipeline: sits between the ID/EX register and memory_access.

---
 rtl/execute_stage.sv | 145 ++++++++++++++
 tb/tb_execute_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: operand forwarding from MA/WB, ALU/shift/LUI/link
// result computation and the registered EX/MA pipeline boundary.
module execute_stage #(
  parameter int unsigned NB_DATA             = 32,
  parameter int unsigned NB_ADDR_REGISTERS   = 5,
  parameter int unsigned NB_CONTROL_EX       = 8,
  parameter int unsigned NB_CONTROL_MA       = 5,
  parameter int unsigned NB_CONTROL_WB       = 2,
  parameter int unsigned NB_CONTROL_EX_MA_WB = NB_CONTROL_EX + NB_CONTROL_MA + NB_CONTROL_WB
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic                                     i_enable,
  input  logic                                     i_flush,
  input  logic [NB_CONTROL_EX_MA_WB-1:0]           i_control_ex_ma_wb,
  input  logic [NB_DATA-1:0]                       i_rs_data,
  input  logic [NB_DATA-1:0]                       i_rt_data,
  input  logic [NB_DATA-1:0]                       i_imm,
  input  logic [4:0]                               i_shamt,
  input  logic [NB_DATA-1:0]                       i_pc_plus8,
  input  logic [NB_ADDR_REGISTERS-1:0]             i_rs_num,
  input  logic [NB_ADDR_REGISTERS-1:0]             i_rt_num,
  input  logic [NB_ADDR_REGISTERS-1:0]             i_rd_num,
  input  logic [NB_ADDR_REGISTERS-1:0]             i_ma_rd_num,
  input  logic                                     i_ma_ctl_reg_write,
  input  logic [NB_DATA-1:0]                       i_ma_rd_data,
  input  logic [NB_ADDR_REGISTERS-1:0]             i_wb_rd_num,
  input  logic                                     i_wb_ctl_reg_write,
  input  logic [NB_DATA-1:0]                       i_wb_rd_data,
  output logic [NB_CONTROL_MA+NB_CONTROL_WB-1:0]   o_control_ma_wb,
  output logic [NB_DATA-1:0]                       o_alu_result,
  output logic [NB_DATA-1:0]                       o_mem_w_data,
  output logic [NB_ADDR_REGISTERS-1:0]             o_rd_num
);

  localparam int unsigned NB_CONTROL_MA_WB = NB_CONTROL_MA + NB_CONTROL_WB;
  localparam int unsigned NB_ALU_OP        = 4;
  localparam int unsigned NB_SHAMT         = 5;
  localparam int unsigned NB_REG_DST       = 2;
  localparam int unsigned TOP              = NB_CONTROL_EX_MA_WB - 1;

  localparam logic [NB_ALU_OP-1:0] ALU_ADD  = 4'd0;
  localparam logic [NB_ALU_OP-1:0] ALU_SUB  = 4'd1;
  localparam logic [NB_ALU_OP-1:0] ALU_AND  = 4'd2;
  localparam logic [NB_ALU_OP-1:0] ALU_OR   = 4'd3;
  localparam logic [NB_ALU_OP-1:0] ALU_XOR  = 4'd4;
  localparam logic [NB_ALU_OP-1:0] ALU_NOR  = 4'd5;
  localparam logic [NB_ALU_OP-1:0] ALU_SLT  = 4'd6;
  localparam logic [NB_ALU_OP-1:0] ALU_SLTU = 4'd7;
  localparam logic [NB_ALU_OP-1:0] ALU_SLL  = 4'd8;
  localparam logic [NB_ALU_OP-1:0] ALU_SRL  = 4'd9;
  localparam logic [NB_ALU_OP-1:0] ALU_SRA  = 4'd10;
  localparam logic [NB_ALU_OP-1:0] ALU_LUI  = 4'd11;
  localparam logic [NB_ALU_OP-1:0] ALU_LINK = 4'd12;

  logic [NB_ALU_OP-1:0]         alu_op;
  logic                         alu_src_imm;
  logic                         shamt_src;
  logic [NB_REG_DST-1:0]        reg_dst;
  logic [NB_DATA-1:0]           fwd_rs;
  logic [NB_DATA-1:0]           fwd_rt;
  logic [NB_DATA-1:0]           op_b;
  logic [NB_SHAMT-1:0]          shamt;
  logic [NB_DATA-1:0]           alu_result_c;
  logic [NB_ADDR_REGISTERS-1:0] rd_num_c;

  // EX control field occupies the MSBs of the control bus
  assign alu_op      = i_control_ex_ma_wb[TOP -: NB_ALU_OP];
  assign alu_src_imm = i_control_ex_ma_wb[TOP - NB_ALU_OP];
  assign shamt_src   = i_control_ex_ma_wb[TOP - NB_ALU_OP - 1];
  assign reg_dst     = i_control_ex_ma_wb[TOP - NB_ALU_OP - 2 -: NB_REG_DST];

  // Forwarding: r0 never forwarded; MA holds the newer value, so it beats WB
  always_comb begin
    fwd_rs = i_rs_data;
    if (i_rs_num != '0) begin
      if (i_ma_ctl_reg_write && (i_ma_rd_num == i_rs_num))      fwd_rs = i_ma_rd_data;
      else if (i_wb_ctl_reg_write && (i_wb_rd_num == i_rs_num)) fwd_rs = i_wb_rd_data;
    end
  end

  always_comb begin
    fwd_rt = i_rt_data;
    if (i_rt_num != '0) begin
      if (i_ma_ctl_reg_write && (i_ma_rd_num == i_rt_num))      fwd_rt = i_ma_rd_data;
      else if (i_wb_ctl_reg_write && (i_wb_rd_num == i_rt_num)) fwd_rt = i_wb_rd_data;
    end
  end

  assign op_b  = alu_src_imm ? i_imm : fwd_rt;
  assign shamt = shamt_src ? i_shamt : fwd_rs[NB_SHAMT-1:0];

  always_comb begin
    alu_result_c = '0;
    case (alu_op)
      ALU_ADD:  alu_result_c = fwd_rs + op_b;
      ALU_SUB:  alu_result_c = fwd_rs - op_b;
      ALU_AND:  alu_result_c = fwd_rs & op_b;
      ALU_OR:   alu_result_c = fwd_rs | op_b;
      ALU_XOR:  alu_result_c = fwd_rs ^ op_b;
      ALU_NOR:  alu_result_c = ~(fwd_rs | op_b);
      ALU_SLT:  alu_result_c = NB_DATA'($signed(fwd_rs) < $signed(op_b));
      ALU_SLTU: alu_result_c = NB_DATA'(fwd_rs < op_b);
      ALU_SLL:  alu_result_c = fwd_rt << shamt;
      ALU_SRL:  alu_result_c = fwd_rt >> shamt;
      ALU_SRA:  alu_result_c = NB_DATA'($signed(fwd_rt) >>> shamt);
      ALU_LUI:  alu_result_c = NB_DATA'({op_b[15:0], 16'h0000});
      ALU_LINK: alu_result_c = i_pc_plus8;
      default:  alu_result_c = '0;
    endcase
  end

  always_comb begin
    rd_num_c = '0;
    case (reg_dst)
      2'd0:    rd_num_c = i_rt_num;
      2'd1:    rd_num_c = i_rd_num;
      2'd2:    rd_num_c = NB_ADDR_REGISTERS'(31);
      default: rd_num_c = '0;
    endcase
  end

  // EX/MA pipeline register; a flush loads a bubble
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_control_ma_wb <= '0;
      o_alu_result    <= '0;
      o_mem_w_data    <= '0;
      o_rd_num        <= '0;
    end else if (i_enable) begin
      if (i_flush) begin
        o_control_ma_wb <= '0;
        o_alu_result    <= '0;
        o_mem_w_data    <= '0;
        o_rd_num        <= '0;
      end else begin
        o_control_ma_wb <= i_control_ex_ma_wb[NB_CONTROL_MA_WB-1:0];
        o_alu_result    <= alu_result_c;
        o_mem_w_data    <= fwd_rt;
        o_rd_num        <= rd_num_c;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against a behavioural reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        flush;
  logic [14:0] ctl;
  logic [31:0] rs_data, rt_data, imm, pc8;
  logic [4:0]  shamt, rs_num, rt_num, rd_num;
  logic [4:0]  ma_num, wb_num;
  logic        ma_we, wb_we;
  logic [31:0] ma_data, wb_data;
  logic [6:0]  o_ctl;
  logic [31:0] o_res, o_wd;
  logic [4:0]  o_rd;

  int checks   = 0;
  int failures = 0;

  logic [6:0]  exp_ctl;
  logic [31:0] exp_res, exp_wd;
  logic [4:0]  exp_rd;

  always #5 clk = ~clk;

  execute_stage dut (
    .i_clk              (clk),
    .i_reset            (rst),
    .i_enable           (en),
    .i_flush            (flush),
    .i_control_ex_ma_wb (ctl),
    .i_rs_data          (rs_data),
    .i_rt_data          (rt_data),
    .i_imm              (imm),
    .i_shamt            (shamt),
    .i_pc_plus8         (pc8),
    .i_rs_num           (rs_num),
    .i_rt_num           (rt_num),
    .i_rd_num           (rd_num),
    .i_ma_rd_num        (ma_num),
    .i_ma_ctl_reg_write (ma_we),
    .i_ma_rd_data       (ma_data),
    .i_wb_rd_num        (wb_num),
    .i_wb_ctl_reg_write (wb_we),
    .i_wb_rd_data       (wb_data),
    .o_control_ma_wb    (o_ctl),
    .o_alu_result       (o_res),
    .o_mem_w_data       (o_wd),
    .o_rd_num           (o_rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Value an operand actually sees: newest in-flight writer of that register, else register file
  function automatic logic [31:0] operand(input logic [4:0] num, input logic [31:0] rf);
    if (num == 5'd0) return rf;
    if (ma_we && ma_num == num) return ma_data;
    if (wb_we && wb_num == num) return wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] ref_result();
    logic [31:0] a, rt, b;
    int          sh;
    longint      sa, sb;
    a  = operand(rs_num, rs_data);
    rt = operand(rt_num, rt_data);
    b  = ctl[10] ? imm : rt;
    sh = ctl[9] ? int'(shamt) : int'(a % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (int'(ctl[14:11]))
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return (sa < sb) ? 32'd1 : 32'd0;
      7:  return (a < b) ? 32'd1 : 32'd0;
      8:  return 32'(longint'(rt) * (64'd1 << sh));
      9:  return 32'(longint'(rt) / (64'd1 << sh));
      10: return 32'(longint'($signed(rt)) >>> sh);
      11: return 32'(longint'(b % 65536) * 65536);
      12: return pc8;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] ref_dest();
    case (int'(ctl[8:7]))
      0:       return rt_num;
      1:       return rd_num;
      2:       return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  // Advance one clock, updating the model's view of the EX/MA register, then compare
  task automatic cycle(input string tag);
    logic [6:0]  n_ctl;
    logic [31:0] n_res, n_wd;
    logic [4:0]  n_rd;
    n_ctl = exp_ctl; n_res = exp_res; n_wd = exp_wd; n_rd = exp_rd;
    if (rst || (en && flush)) begin
      n_ctl = '0; n_res = '0; n_wd = '0; n_rd = '0;
    end else if (en) begin
      n_ctl = ctl[6:0];
      n_res = ref_result();
      n_wd  = operand(rt_num, rt_data);
      n_rd  = ref_dest();
    end
    @(posedge clk);
    #1;
    exp_ctl = n_ctl; exp_res = n_res; exp_wd = n_wd; exp_rd = n_rd;
    check({tag, "_ctl"}, 32'(o_ctl), 32'(exp_ctl));
    check({tag, "_res"}, o_res, exp_res);
    check({tag, "_wd"},  o_wd,  exp_wd);
    check({tag, "_rd"},  32'(o_rd), 32'(exp_rd));
  endtask

  task automatic set_op(input logic [3:0] op, input logic isrc, input logic ssrc,
                        input logic [1:0] rdst, input logic [6:0] mawb);
    ctl = {op, isrc, ssrc, rdst, mawb};
  endtask

  task automatic no_fwd();
    ma_we = 1'b0; wb_we = 1'b0; ma_num = 5'd0; wb_num = 5'd0; ma_data = '0; wb_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    ctl = '0; rs_data = '0; rt_data = '0; imm = '0; pc8 = '0; shamt = '0;
    rs_num = '0; rt_num = '0; rd_num = '0;
    no_fwd();
    exp_ctl = '0; exp_res = '0; exp_wd = '0; exp_rd = '0;
    @(posedge clk); #1;
    cycle("reset");

    // Reset mid-stream with an ADD in flight
    rst = 1'b0;
    set_op(4'd0, 1'b0, 1'b0, 2'd1, 7'h01);
    rs_num = 5'd3; rt_num = 5'd3; rd_num = 5'd9; rs_data = 32'd5; rt_data = 32'd7;
    cycle("add");
    check("add_const", o_res, 32'd12);
    check("add_rd_const", 32'(o_rd), 32'd9);
    rst = 1'b1;
    cycle("midrst");
    check("midrst_res_const", o_res, 32'd0);
    rst = 1'b0;

    // SUB with both MA and WB writing rs: MA wins
    set_op(4'd1, 1'b0, 1'b0, 2'd1, 7'h01);
    rs_num = 5'd4; rt_num = 5'd5; rd_num = 5'd6; rs_data = 32'd1; rt_data = 32'd30;
    ma_we = 1'b1; ma_num = 5'd4; ma_data = 32'd100;
    wb_we = 1'b1; wb_num = 5'd4; wb_data = 32'd50;
    cycle("sub_fwd");
    check("sub_fwd_const", o_res, 32'd70);

    // r0 is never forwarded
    set_op(4'd0, 1'b1, 1'b0, 2'd0, 7'h01);
    no_fwd();
    rs_num = 5'd0; rs_data = 32'd0; rt_num = 5'd2; imm = 32'd3;
    ma_we = 1'b1; ma_num = 5'd0; ma_data = 32'h0000_FFFF;
    cycle("r0");
    check("r0_const", o_res, 32'd3);
    no_fwd();

    set_op(4'd10, 1'b0, 1'b1, 2'd0, 7'h01);
    rt_num = 5'd6; rt_data = 32'h8000_0000; shamt = 5'd4;
    cycle("sra");
    check("sra_const", o_res, 32'hF800_0000);

    set_op(4'd6, 1'b0, 1'b0, 2'd1, 7'h01);
    rs_num = 5'd7; rs_data = 32'hFFFF_FFFF; rt_num = 5'd8; rt_data = 32'd1;
    cycle("slt");
    check("slt_const", o_res, 32'd1);
    set_op(4'd7, 1'b0, 1'b0, 2'd1, 7'h01);
    cycle("sltu");
    check("sltu_const", o_res, 32'd0);

    set_op(4'd11, 1'b1, 1'b0, 2'd0, 7'h01);
    imm = 32'h0000_1234;
    cycle("lui");
    check("lui_const", o_res, 32'h1234_0000);

    // JAL, then hold, then flush
    set_op(4'd12, 1'b0, 1'b0, 2'd2, 7'h01);
    pc8 = 32'h40;
    cycle("jal");
    check("jal_const", o_res, 32'h40);
    check("jal_rd_const", 32'(o_rd), 32'd31);
    en = 1'b0; flush = 1'b1;
    set_op(4'd0, 1'b0, 1'b0, 2'd1, 7'h7F);
    cycle("hold");
    check("hold_const", o_res, 32'h40);
    en = 1'b1;
    cycle("flush");
    check("flush_ctl_const", 32'(o_ctl), 32'd0);
    flush = 1'b0;

    // Random traffic; small register range to provoke forwarding hits
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 49) == 0);
      en      = ($urandom_range(0, 7) != 0);
      flush   = ($urandom_range(0, 9) == 0);
      ctl     = 15'($urandom);
      rs_data = $urandom; rt_data = $urandom; imm = $urandom; pc8 = $urandom;
      shamt   = 5'($urandom);
      rs_num  = 5'($urandom_range(0, 3)); rt_num = 5'($urandom_range(0, 3));
      rd_num  = 5'($urandom);
      ma_num  = 5'($urandom_range(0, 3)); wb_num = 5'($urandom_range(0, 3));
      ma_we   = 1'($urandom); wb_we = 1'($urandom);
      ma_data = $urandom; wb_data = $urandom;
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
